mux_nx1_rr_arbiter: RTL

//  Round-robin arbiter that shares one mux_nx1 datapath among SIZE requesters.

---
 rtl/mux_nx1_rr_arbiter_if.sv | 29 ++
 rtl/mux_nx1_rr_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/mux_nx1_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
// The arbiter's select output is intended to drive the downstream mux_nx1 select.
interface mux_nx1_rr_arbiter_if #(
  parameter int unsigned SIZE = 8
);
  localparam int unsigned SEL_W = $clog2(SIZE);

  logic [SIZE-1:0]  arb_req;
  logic             arb_done;
  logic [SIZE-1:0]  arb_grant;
  logic [SEL_W-1:0] arb_sel;
  logic             arb_valid;

  modport master (
    output arb_req,
    output arb_done,
    input  arb_grant,
    input  arb_sel,
    input  arb_valid
  );

  modport slave (
    input  arb_req,
    input  arb_done,
    output arb_grant,
    output arb_sel,
    output arb_valid
  );
endinterface

// File: rtl/mux_nx1_rr_arbiter.sv
// Round-robin arbiter sharing one mux_nx1 datapath among SIZE requesters.
// Grants are registered, held until release or hold timeout, with one bubble after each release.
module mux_nx1_rr_arbiter #(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  mux_nx1_rr_arbiter_if.slave arb
);
  localparam int unsigned SEL_W = $clog2(SIZE);
  localparam int unsigned IW    = SEL_W + 1;
  localparam int unsigned HW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [HW-1:0]    HoldLast = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0] SelLast  = SEL_W'(SIZE - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q;
  logic [SIZE-1:0]  grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic [HW-1:0]    hold_q;
  logic             valid_q;

  logic [SEL_W-1:0] winner;
  logic             found;
  logic [IW-1:0]    idx;
  logic             other_req;
  logic             timeout;
  logic             release_grant;

  // Scan ptr, ptr+1, ... modulo SIZE; the extra index bit keeps the wrap exact for any SIZE.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      idx = {1'b0, ptr_q} + IW'(i);
      if (idx >= IW'(SIZE)) begin
        idx = idx - IW'(SIZE);
      end
      if (!found && arb.arb_req[idx[SEL_W-1:0]]) begin
        winner = idx[SEL_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    other_req     = |(arb.arb_req & ~grant_q);
    timeout       = (MAX_HOLD != 0) && (hold_q == HoldLast) && other_req;
    release_grant = arb.arb_done || !arb.arb_req[sel_q] || timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            grant_q <= SIZE'(1) << winner;
            sel_q   <= winner;
            valid_q <= 1'b1;
            hold_q  <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (release_grant) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= (sel_q == SelLast) ? '0 : sel_q + 1'b1;
            state_q <= StIdle;
          end else if (hold_q != HoldLast) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign arb.arb_grant = grant_q;
  assign arb.arb_sel   = sel_q;
  assign arb.arb_valid = valid_q;
endmodule
